uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- 8N1 UART receiver: the receive end of the team's UART transmitter, which sends a low start bit, 8 data bits LSB first, and a high stop bit.
- Oversamples the asynchronous serial line with a bit-period counter and samples each bit at mid-period.
- Delivers each received byte with a one-cycle valid strobe.
- Flags stop-bit (framing) errors.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; must be even and >= 4.
- DATA_BITS, 8, data bits per frame.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- rx  input  1  serial line, asynchronous to clk; idles high.
- rx_data  output  DATA_BITS  last correctly framed byte; bit 0 is the first data bit received.
- rx_valid  output  1  one-cycle pulse: rx_data was just updated.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state = IDLE, counters = 0, shift register = 0.
  - rx_data = 0, rx_valid = 0, frame_err = 0, busy = 0.
  - Both synchronizer flops preset to 1 (line idle).
  - Reset asserted mid-frame aborts the frame; no rx_valid or frame_err is produced.
- Input sync: rx passes through a 2-flop synchronizer giving rx_s. All decisions use rx_s only.
- HALF = CLKS_PER_BIT/2. cnt is a bit-period counter, bit_idx counts 0..DATA_BITS-1.
- IDLE:
  - On a clock edge with rx_s = 0: go to START, cnt = 0.
- START:
  - cnt increments each cycle.
  - At the edge where cnt = HALF-1, sample rx_s.
  - Sample 0: go to DATA, cnt = 0, bit_idx = 0.
  - Sample 1 (glitch / false start): go to IDLE with no output.
- DATA:
  - cnt increments; at cnt = CLKS_PER_BIT-1, sample rx_s and reset cnt to 0.
  - The sample shifts into the MSB of the shift register (right shift), so the first bit received ends in bit 0.
  - After the sample with bit_idx = DATA_BITS-1: go to STOP, cnt = 0. Otherwise bit_idx increments.
- STOP:
  - At cnt = CLKS_PER_BIT-1, sample rx_s.
  - Sample 1: rx_data <= shift register, rx_valid = 1 for exactly one cycle, go to IDLE.
  - Sample 0: rx_data unchanged, frame_err = 1 for exactly one cycle, go to WAIT_IDLE.
- WAIT_IDLE (break / stuck-low line):
  - Stay until rx_s = 1, then go to IDLE.
  - No new start is detected while the line stays low.
- Latency: rx falls just after edge t0 → rx_valid (or frame_err) is high in the cycle after edge t0 + 3 + (HALF-1) + (DATA_BITS+1)·CLKS_PER_BIT.
  - Defaults: t0 + 154.
- Back-to-back frames:
  - A start bit immediately following a stop bit is accepted; IDLE re-arms on the cycle after the stop sample.
  - No dead time beyond that is required.
- rx_valid and frame_err are never high in the same cycle.
- rx_data holds its value until the next good frame.
- busy = 0 only in IDLE; busy = 1 in START, DATA, STOP and WAIT_IDLE.
- No backpressure: a consumer must take rx_data within one frame time.

Test Plan:
1. Defaults, send frame 0xA5 (line: 0, 1,0,1,0,0,1,0,1, 1) at 16 clk/bit → rx_data = 0xA5, rx_valid high for exactly 1 cycle at t0+154, frame_err stays 0.
2. Two back-to-back frames, 0x00 then 0xFF, with no idle gap → two rx_valid pulses 160 cycles apart, with rx_data = 0x00 then 0xFF.
3. Frame 0x3C with stop bit driven low, then line held low 40 bit times, then high, then frame 0x81 →
   - frame_err pulses once; no rx_valid; rx_data stays at its previous value;
   - busy stays high until the line returns high;
   - 0x81 is then received correctly.
4. Glitch: rx low for 4 cycles then high → returns to IDLE at the mid-start sample; no rx_valid, no frame_err; busy deasserts.
5. Assert reset during data bit 4 of a frame, release, then send 0x5A → all outputs 0 during reset; the aborted frame produces nothing; 0x5A is received correctly.
6. CLKS_PER_BIT = 4: send 0xC3 → rx_valid at t0+3+1+36 = t0+40 with rx_data = 0xC3.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchronizer and mid-bit sampling.
// Delivers each good byte with a one-cycle rx_valid strobe and flags bad stop bits.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int unsigned HALF  = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic                 r_sync_1;
  logic                 r_rx_s;
  logic [2:0]           r_state;
  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [DATA_BITS-1:0] r_shift;

  logic [2:0]           w_state_nxt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_valid_nxt;
  logic                 w_ferr_nxt;
  logic                 w_bit_end;

  // Two-flop synchronizer; presets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync_1 <= 1'b1;
      r_rx_s   <= 1'b1;
    end else begin
      r_sync_1 <= rx;
      r_rx_s   <= r_sync_1;
    end
  end

  // Last cycle of a full bit period in DATA/STOP.
  assign w_bit_end = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  // Next-state, datapath and output-strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = rx_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rx_s) begin
          w_state_nxt = S_START;
          w_cnt_nxt   = '0;
        end
      end
      S_START: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        // Mid-start check as the counter reaches HALF-1; a high line here is a glitch.
        if (r_cnt == CNT_W'(HALF - 2)) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt = S_DATA;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_bit_end) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[DATA_BITS-1:1]};
          if (r_idx == IDX_W'(DATA_BITS - 1)) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (w_bit_end) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        // Break / stuck-low line: no new start until the line recovers.
        if (r_rx_s) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      rx_data   <= w_data_nxt;
      rx_valid  <= w_valid_nxt;
      frame_err <= w_ferr_nxt;
      busy      <= (w_state_nxt != S_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into two receivers (16 and 4 clk/bit); a monitor
// pops expected events from per-DUT queues whenever a strobe appears.
module tb_uart_rx;

  localparam int unsigned CPB_A = 16;
  localparam int unsigned CPB_B = 4;

  typedef struct {
    logic       kind;   // 0: rx_valid, 1: frame_err
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_a  = 1'b1;
  logic       rx_b  = 1'b1;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_valid_a, rx_valid_b;
  logic       frame_err_a, frame_err_b;
  logic       busy_a, busy_b;

  exp_t       q_a[$];
  exp_t       q_b[$];
  int         cyc     = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] last_a  = 8'h00;
  logic [7:0] last_b  = 8'h00;
  logic [7:0] pat;

  uart_rx #(.CLKS_PER_BIT(CPB_A), .DATA_BITS(8)) u_dut_a (
    .clk(clk), .reset(rst_n), .rx(rx_a),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .frame_err(frame_err_a), .busy(busy_a)
  );

  uart_rx #(.CLKS_PER_BIT(CPB_B), .DATA_BITS(8)) u_dut_b (
    .clk(clk), .reset(rst_n), .rx(rx_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .frame_err(frame_err_b), .busy(busy_b)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge N settles, cyc == N.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller is positioned #1 after a posedge; that edge is t0.
  task automatic send(input bit sel, input logic [7:0] d, input logic stop_bit, input int lat);
    logic [9:0] bits;
    exp_t       e;
    int         cpb;
    cpb    = sel ? CPB_B : CPB_A;
    bits   = {stop_bit, d, 1'b0};
    e.kind = ~stop_bit;
    e.cyc  = cyc + lat;
    if (sel) begin
      e.data = stop_bit ? d : last_b;
      if (stop_bit) last_b = d;
      q_b.push_back(e);
    end else begin
      e.data = stop_bit ? d : last_a;
      if (stop_bit) last_a = d;
      q_a.push_back(e);
    end
    for (int i = 0; i < 10; i++) begin
      if (sel) rx_b = bits[i];
      else     rx_a = bits[i];
      wait_cyc(cpb);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_data_a"},  32'(rx_data_a),   32'd0);
    chk({tag, "_valid_a"}, 32'(rx_valid_a),  32'd0);
    chk({tag, "_ferr_a"},  32'(frame_err_a), 32'd0);
    chk({tag, "_busy_a"},  32'(busy_a),      32'd0);
    chk({tag, "_data_b"},  32'(rx_data_b),   32'd0);
    chk({tag, "_valid_b"}, 32'(rx_valid_b),  32'd0);
    chk({tag, "_ferr_b"},  32'(frame_err_b), 32'd0);
    chk({tag, "_busy_b"},  32'(busy_b),      32'd0);
  endtask

  task automatic check_evt(input string tag, input exp_t e, input logic v, input logic f,
                           input logic [7:0] d);
    chk({tag, "_excl"}, 32'(v & f),  32'd0);
    chk({tag, "_kind"}, 32'(f),      32'(e.kind));
    chk({tag, "_data"}, 32'(d),      32'(e.data));
    chk({tag, "_time"}, 32'(cyc),    32'(e.cyc));
  endtask

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    exp_t e;
    if (rx_valid_a || frame_err_a) begin
      if (q_a.size() == 0) chk("unexpected_a", 32'({frame_err_a, rx_valid_a}), 32'd0);
      else begin
        e = q_a.pop_front();
        check_evt("evt_a", e, rx_valid_a, frame_err_a, rx_data_a);
      end
    end
    if (rx_valid_b || frame_err_b) begin
      if (q_b.size() == 0) chk("unexpected_b", 32'({frame_err_b, rx_valid_b}), 32'd0);
      else begin
        e = q_b.pop_front();
        check_evt("evt_b", e, rx_valid_b, frame_err_b, rx_data_b);
      end
    end
  end

  initial begin
    // Reset state
    wait_cyc(3);
    chk_zero("reset");
    rst_n = 1'b1;
    wait_cyc(5);

    // 1: single frame 0xA5
    send(1'b0, 8'hA5, 1'b1, 154);
    wait_cyc(20);

    // 2: back-to-back 0x00, 0xFF (expected strobes 160 cycles apart)
    send(1'b0, 8'h00, 1'b1, 154);
    send(1'b0, 8'hFF, 1'b1, 154);
    wait_cyc(20);

    // 3: bad stop bit, line held low 40 bit times, then recovery and 0x81
    send(1'b0, 8'h3C, 1'b0, 154);
    wait_cyc(320);
    chk("break_busy_mid", 32'(busy_a), 32'd1);
    wait_cyc(320);
    chk("break_busy_end", 32'(busy_a), 32'd1);
    chk("break_data_held", 32'(rx_data_a), 32'hFF);
    rx_a = 1'b1;
    wait_cyc(2);
    chk("break_busy_sync", 32'(busy_a), 32'd1);
    wait_cyc(3);
    chk("break_busy_clear", 32'(busy_a), 32'd0);
    wait_cyc(27);
    send(1'b0, 8'h81, 1'b1, 154);
    wait_cyc(20);

    // 4: 4-cycle glitch rejected at the mid-start sample
    rx_a = 1'b0;
    wait_cyc(4);
    rx_a = 1'b1;
    chk("glitch_busy_start", 32'(busy_a), 32'd1);
    wait_cyc(10);
    chk("glitch_busy_idle", 32'(busy_a), 32'd0);
    chk("glitch_data_held", 32'(rx_data_a), 32'h81);
    wait_cyc(20);

    // 5: reset during data bit 4, then 0x5A
    pat  = 8'h96;
    rx_a = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 4; i++) begin
      rx_a = pat[i];
      wait_cyc(16);
    end
    rx_a = pat[4];
    wait_cyc(8);
    rst_n = 1'b0;
    #1;
    chk_zero("midreset");
    last_a = 8'h00;
    wait_cyc(3);
    rx_a  = 1'b1;
    rst_n = 1'b1;
    wait_cyc(200);
    chk("post_reset_data", 32'(rx_data_a), 32'd0);
    send(1'b0, 8'h5A, 1'b1, 154);
    wait_cyc(20);

    // 6: 4 clk/bit instance receives 0xC3
    send(1'b1, 8'hC3, 1'b1, 40);
    wait_cyc(20);

    chk("drain_a", 32'(q_a.size()), 32'd0);
    chk("drain_b", 32'(q_b.size()), 32'd0);
    chk("final_data_a", 32'(rx_data_a), 32'h5A);
    chk("final_data_b", 32'(rx_data_b), 32'hC3);
    chk("final_busy_a", 32'(busy_a), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
